// File: rtl/synth_pkg.sv
// Shared types and default sizes for the synth voice path.
package synth_pkg;
  localparam int NUM_VOICES_DEF = 8;
  localparam int NOTE_W_DEF     = 7;
  localparam int VEL_W_DEF      = 3;
  localparam int AGE_W_DEF      = 4;

  typedef logic [NOTE_W_DEF-1:0] note_t;
  typedef logic [VEL_W_DEF-1:0]  vel_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2
  } alloc_state_t;
endpackage

// File: rtl/voice_slot.sv
// One voice slot: gate, note, velocity and saturating age, driven by load/release/age commands.
module voice_slot
  import synth_pkg::*;
#(
  parameter int NOTE_W = NOTE_W_DEF,
  parameter int VEL_W  = VEL_W_DEF,
  parameter int AGE_W  = AGE_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_load,
  input  logic              i_release,
  input  logic              i_age_inc,
  input  logic [NOTE_W-1:0] i_note,
  input  logic [VEL_W-1:0]  i_vel,
  output logic              o_on,
  output logic [NOTE_W-1:0] o_note,
  output logic [VEL_W-1:0]  o_vel,
  output logic [AGE_W-1:0]  o_age,
  output logic              o_trig
);
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  logic              r_on;
  logic [NOTE_W-1:0] r_note;
  logic [VEL_W-1:0]  r_vel;
  logic [AGE_W-1:0]  r_age;
  logic              r_trig;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_on   <= 1'b0;
      r_note <= '0;
      r_vel  <= '0;
      r_age  <= '0;
      r_trig <= 1'b0;
    end else if (i_clr) begin
      // panic release keeps note/vel so the release tail still has its pitch
      r_on   <= 1'b0;
      r_age  <= '0;
      r_trig <= 1'b0;
    end else begin
      r_trig <= i_load;
      if (i_load) begin
        r_on   <= 1'b1;
        r_note <= i_note;
        r_vel  <= i_vel;
        r_age  <= '0;
      end else if (i_release) begin
        r_on <= 1'b0;
      end else if (i_age_inc && r_on && r_age != AGE_MAX) begin
        r_age <= r_age + 1'b1;
      end
    end
  end

  assign o_on   = r_on;
  assign o_note = r_note;
  assign o_vel  = r_vel;
  assign o_age  = r_age;
  assign o_trig = r_trig;
endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: serial scan over the slots, then a single commit cycle
// that retriggers a held note, fills the lowest free slot, or steals the oldest voice.
module voice_allocator
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = NUM_VOICES_DEF,
  parameter int NOTE_W     = NOTE_W_DEF,
  parameter int VEL_W      = VEL_W_DEF,
  parameter int AGE_W      = AGE_W_DEF
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              ev_valid,
  output logic                              ev_ready,
  input  logic                              ev_is_on,
  input  logic [NOTE_W-1:0]                 ev_note,
  input  logic [VEL_W-1:0]                  ev_vel,
  input  logic                              all_off,
  output logic [NUM_VOICES-1:0]             voice_on,
  output logic [NUM_VOICES-1:0][NOTE_W-1:0] voice_note,
  output logic [NUM_VOICES-1:0][VEL_W-1:0]  voice_vel,
  output logic [NUM_VOICES-1:0]             voice_trig,
  output logic                              steal
);
  localparam int IDX_W = $clog2(NUM_VOICES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  alloc_state_t      r_state;
  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  r_match_idx, r_free_idx, r_old_idx;
  logic              r_match_fnd, r_free_fnd, r_old_fnd;
  logic [AGE_W-1:0]  r_max_age;
  logic              r_ev_on;
  logic [NOTE_W-1:0] r_ev_note;
  logic [VEL_W-1:0]  r_ev_vel;
  logic              r_steal;

  logic [NUM_VOICES-1:0][AGE_W-1:0] w_age;
  logic [NUM_VOICES-1:0]            w_load, w_rel, w_inc;
  logic                             w_cur_on;
  logic [NOTE_W-1:0]                w_cur_note;
  logic [AGE_W-1:0]                 w_cur_age;
  logic                             w_commit, w_note_on, w_steal_nxt;
  logic [IDX_W-1:0]                 w_tgt;

  assign ev_ready    = (r_state == IDLE) && rst && !all_off;
  assign w_cur_on    = voice_on[r_idx];
  assign w_cur_note  = voice_note[r_idx];
  assign w_cur_age   = w_age[r_idx];
  assign w_commit    = (r_state == COMMIT);
  assign w_note_on   = r_ev_on && (r_ev_vel != '0);
  assign w_tgt       = r_match_fnd ? r_match_idx : (r_free_fnd ? r_free_idx : r_old_idx);
  assign w_steal_nxt = w_commit && w_note_on && !r_match_fnd && !r_free_fnd;
  assign steal       = r_steal;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_match_idx <= '0;
      r_free_idx  <= '0;
      r_old_idx   <= '0;
      r_match_fnd <= 1'b0;
      r_free_fnd  <= 1'b0;
      r_old_fnd   <= 1'b0;
      r_max_age   <= '0;
      r_ev_on     <= 1'b0;
      r_ev_note   <= '0;
      r_ev_vel    <= '0;
      r_steal     <= 1'b0;
    end else if (all_off) begin
      r_state <= IDLE;
      r_steal <= 1'b0;
    end else begin
      r_steal <= w_steal_nxt;
      case (r_state)
        IDLE: if (ev_valid) begin
          r_ev_on     <= ev_is_on;
          r_ev_note   <= ev_note;
          r_ev_vel    <= ev_vel;
          r_idx       <= '0;
          r_match_fnd <= 1'b0;
          r_free_fnd  <= 1'b0;
          r_old_fnd   <= 1'b0;
          r_max_age   <= '0;
          r_state     <= SCAN;
        end
        SCAN: begin
          if (!r_match_fnd && w_cur_on && w_cur_note == r_ev_note) begin
            r_match_fnd <= 1'b1;
            r_match_idx <= r_idx;
          end
          if (!r_free_fnd && !w_cur_on) begin
            r_free_fnd <= 1'b1;
            r_free_idx <= r_idx;
          end
          // strict compare keeps the lower index on equal ages
          if (w_cur_on && (!r_old_fnd || w_cur_age > r_max_age)) begin
            r_old_fnd <= 1'b1;
            r_old_idx <= r_idx;
            r_max_age <= w_cur_age;
          end
          if (r_idx == LAST_IDX) r_state <= COMMIT;
          else                   r_idx   <= r_idx + 1'b1;
        end
        COMMIT:  r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    w_load = '0;
    w_rel  = '0;
    w_inc  = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (w_commit && w_note_on) begin
        if (IDX_W'(i) == w_tgt) w_load[i] = 1'b1;
        else                    w_inc[i]  = 1'b1;
      end
      if (w_commit && !w_note_on && r_match_fnd && IDX_W'(i) == r_match_idx)
        w_rel[i] = 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_slot
    voice_slot #(
      .NOTE_W (NOTE_W),
      .VEL_W  (VEL_W),
      .AGE_W  (AGE_W)
    ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .i_clr     (all_off),
      .i_load    (w_load[g]),
      .i_release (w_rel[g]),
      .i_age_inc (w_inc[g]),
      .i_note    (r_ev_note),
      .i_vel     (r_ev_vel),
      .o_on      (voice_on[g]),
      .o_note    (voice_note[g]),
      .o_vel     (voice_vel[g]),
      .o_age     (w_age[g]),
      .o_trig    (voice_trig[g])
    );
  end
endmodule
